// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller and its mm:ss counter.
// MAX_VAL is the terminal value for both fields; 59:59 is the saturating end point.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_VAL = 8'd59;

    typedef struct packed {
        logic [7:0] minute;
        logic [7:0] second;
    } time_t;

    // One-second advance of an mm:ss value, saturating at MAX_VAL:MAX_VAL.
    function automatic time_t time_inc(time_t t);
        time_t n;
        n = t;
        if (t.second < MAX_VAL) begin
            n.second = t.second + 8'd1;
        end else if (t.minute < MAX_VAL) begin
            n.second = 8'd0;
            n.minute = t.minute + 8'd1;
        end
        return n;
    endfunction

    function automatic logic time_at_max(time_t t);
        return (t.minute == MAX_VAL) && (t.second == MAX_VAL);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_mmss_counter.sv
// Minute:second counter. Advances one second per enable pulse, saturates at
// MAX_VAL:MAX_VAL, and clears synchronously with priority over enable.
module mmss_counter
    import stopwatch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] second,
    output logic [7:0] minute,
    output logic       at_max
);

    time_t cur_t;
    time_t nxt_t;

    assign cur_t  = {minute, second};
    assign nxt_t  = time_inc(cur_t);
    assign at_max = time_at_max(cur_t);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second <= 8'd0;
            minute <= 8'd0;
        end else if (clr) begin
            second <= 8'd0;
            minute <= 8'd0;
        end else if (en) begin
            second <= nxt_t.second;
            minute <= nxt_t.minute;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch: prescaler-derived one-second tick, 4-state FSM,
// lap capture and a sticky alarm compare around an mm:ss counter.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    input  logic       alarm_en,
    input  logic [7:0] alarm_min,
    input  logic [7:0] alarm_sec,
    output logic [7:0] second,
    output logic [7:0] minute,
    output logic [7:0] lap_second,
    output logic [7:0] lap_minute,
    output logic       lap_valid,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic          at_max;
    time_t         cur_t;
    time_t         nxt_t;

    assign tick  = (state == RUN) && (presc == PRESC_LAST);
    assign cur_t = {minute, second};
    assign nxt_t = time_inc(cur_t);

    mmss_counter u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick && !at_max),
        .clr    (clear),
        .second (second),
        .minute (minute),
        .at_max (at_max)
    );

    // Reaching the terminal value outranks a same-edge stop so the block
    // cannot be parked in PAUSE at 59:59 and later resume without finishing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            running    <= 1'b0;
            done       <= 1'b0;
            presc      <= '0;
            lap_second <= 8'd0;
            lap_minute <= 8'd0;
            lap_valid  <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            lap_valid <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                running    <= 1'b0;
                done       <= 1'b0;
                presc      <= '0;
                lap_second <= 8'd0;
                lap_minute <= 8'd0;
                alarm      <= 1'b0;
            end else begin
                // Lap samples the pre-increment value on a tick edge.
                if (lap && (state == RUN || state == PAUSE)) begin
                    lap_second <= second;
                    lap_minute <= minute;
                    lap_valid  <= 1'b1;
                end

                if (!alarm_en)
                    alarm <= 1'b0;
                else if (tick && nxt_t.minute == alarm_min && nxt_t.second == alarm_sec)
                    alarm <= 1'b1;

                if (state == RUN)
                    presc <= tick ? '0 : presc + 1'b1;

                if (tick && time_at_max(nxt_t)) begin
                    state   <= DONE;
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    case (state)
                        IDLE: if (start && !stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                            presc   <= '0;
                        end
                        RUN: if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                        PAUSE: if (start && !stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
